seg7_readback_decoder: RTL and testbench
========================================

// Module: seg7_readback_decoder
// PURPOSE
//  Receive-side peer of the CPU's four-digit seven-segment display outputs.
//  Samples the 28 segment lines (DnBB0..DnBB6, n=1..4) and waits until the pattern is stable.
//  Decodes each digit back into a hex nibble and publishes a 16-bit value with a one-cycle strobe.
//  Used in benches and on-chip self-check logic to read what the core is displaying.
// PARAMETERS
//  STABLE_CYCLES   4  consecutive identical samples required before publishing (>=1)
//  SEG_ACTIVE_LOW  1  1: a lit segment is driven 0; 0: a lit segment is driven 1
//  CNT_W           8  width of update_count
// PORTS
//  clk           in   1      system clock, rising edge
//  reset         in   1      asynchronous, active-low reset
//  d1_seg        in   7      digit 1 segments, bit k = D1BBk (k=0 seg a .. k=6 seg g)
//  d2_seg        in   7      digit 2 segments, same bit mapping
//  d3_seg        in   7      digit 3 segments
//  d4_seg        in   7      digit 4 segments
//  value         out  16     last published value: d1=[15:12], d2=[11:8], d3=[7:4], d4=[3:0]
//  blank_mask    out  4      bit3=d1 .. bit0=d4; 1 = digit blank (its nibble reads 0)
//  value_valid   out  1      1-cycle pulse when value/blank_mask update
//  seg_error     out  1      1-cycle pulse when a stable pattern holds an undecodable digit
//  invalid_mask  out  4      digits that were undecodable at the last stable pattern (same bit order)
//  update_count  out  CNT_W  number of value_valid pulses since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): all outputs 0.
//    - Sample register loads the all-segments-off pattern.
//    - Run counter = 0, state = SETTLE, no previous publication.
//  - Sampling: the 28 inputs are registered every edge into s_q.
//    - Polarity is normalised to lit = 1 using SEG_ACTIVE_LOW.
//  - Run counter:
//    - Set to 1 when s_q loads a value different from its previous value.
//    - Otherwise increments, saturating at STABLE_CYCLES.
//  - Decode table (lit-high, bits gfedcba):
//    - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//    - 00 = blank; any other code is invalid.
//  - FSM states: SETTLE, LOCKED.
//    - SETTLE -> LOCKED on the edge where the run counter reaches STABLE_CYCLES.
//      - All digits valid or blank: register value/blank_mask and clear invalid_mask.
//        - value_valid=1 and update_count+=1 only if {value,blank_mask} differs from the last publication, or on the first publication since reset.
//      - Any digit invalid: seg_error=1 and invalid_mask updated.
//        - value, blank_mask and update_count are held.
//    - LOCKED -> SETTLE on any change of s_q; the run counter restarts at 1.
//    - LOCKED holds otherwise; no repeated pulses.
//  - Latency: pins change before edge E and then hold; value_valid is high in the cycle after edge E+STABLE_CYCLES.
//    - That is STABLE_CYCLES+1 clocks from pin change to strobe.
//  - Glitch: a pattern held for fewer than STABLE_CYCLES samples is never published.
//    - A return to the already-published pattern after a glitch gives no new pulse.
//  - value_valid and seg_error are never high in the same cycle.
//  - update_count wraps from 2^CNT_W-1 to 0 silently.
//  - Reset asserted mid-SETTLE discards the pending pattern; a full STABLE_CYCLES run is needed after release.
// TESTING
//  1 Reset release, segments held all-off
//    -> value=0000, blank_mask=F, value_valid pulses at clock 5, update_count=1.
//  2 Apply "1234" (06,5B,4F,66 lit-high, inverted on pins) and hold
//    -> value=1234, blank_mask=0, one pulse exactly 5 clocks after the pin change.
//  3 After 1234 is locked, drive d4 to "5" for 2 cycles, then back to "4"
//    -> no value_valid, value stays 1234, update_count unchanged.
//  4 Drive d2=0x49 (invalid) stable for 4 cycles
//    -> seg_error 1-cycle pulse, invalid_mask=4'b0100, value still 1234.
//  5 Start "ABCD", assert reset after 2 cycles, release, hold "ABCD"
//    -> outputs 0 during reset, then value=ABCD 5 clocks after release, update_count=1.
//  6 With CNT_W=2, publish 5 distinct values -> update_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/seg7_readback_decoder.sv
// Seven-segment readback decoder: samples four digit segment buses,
// waits for a stable pattern, decodes it to hex and publishes it.
module seg7_readback_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       d1_seg,
    input  logic [6:0]       d2_seg,
    input  logic [6:0]       d3_seg,
    input  logic [6:0]       d4_seg,
    output logic [15:0]      value,
    output logic [3:0]       blank_mask,
    output logic             value_valid,
    output logic             seg_error,
    output logic [3:0]       invalid_mask,
    output logic [CNT_W-1:0] update_count
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Decode one lit-high gfedcba code into {ok, blank, nibble}.
    function automatic logic [5:0] seg_decode(input logic [6:0] code);
        logic [5:0] r;
        case (code)
            7'h3F:   r = 6'b10_0000;
            7'h06:   r = 6'b10_0001;
            7'h5B:   r = 6'b10_0010;
            7'h4F:   r = 6'b10_0011;
            7'h66:   r = 6'b10_0100;
            7'h6D:   r = 6'b10_0101;
            7'h7D:   r = 6'b10_0110;
            7'h07:   r = 6'b10_0111;
            7'h7F:   r = 6'b10_1000;
            7'h6F:   r = 6'b10_1001;
            7'h77:   r = 6'b10_1010;
            7'h7C:   r = 6'b10_1011;
            7'h39:   r = 6'b10_1100;
            7'h5E:   r = 6'b10_1101;
            7'h79:   r = 6'b10_1110;
            7'h71:   r = 6'b10_1111;
            7'h00:   r = 6'b11_0000;
            default: r = 6'b00_0000;
        endcase
        return r;
    endfunction

    logic [27:0]      pins;
    logic [27:0]      sample;
    logic [27:0]      s_q;
    logic             changed;
    logic [RUN_W-1:0] run_q;
    state_t           state_q;
    state_t           state_d;
    logic             pub_q;

    logic [5:0]       dec [4];
    logic [15:0]      dec_value;
    logic [3:0]       dec_blank;
    logic [3:0]       dec_invalid;
    logic             all_ok;

    logic             evaluate;
    logic             pub_new;
    logic             err_new;

    // Digit 4 sits in the low bits so digit index matches mask bit index.
    assign pins    = {d1_seg, d2_seg, d3_seg, d4_seg};
    assign sample  = SEG_ACTIVE_LOW ? ~pins : pins;
    assign changed = (sample != s_q);

    // Register the normalised segment lines; reset loads all-off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= '0;
        end else begin
            s_q <= sample;
        end
    end

    // Count consecutive identical samples, saturating at the threshold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= '0;
        end else if (changed) begin
            run_q <= RUN_W'(1);
        end else if (run_q != RUN_MAX) begin
            run_q <= run_q + 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_dec
        assign dec[i] = seg_decode(s_q[i*7 +: 7]);
        assign dec_value[i*4 +: 4] = dec[i][3:0];
        assign dec_blank[i]        = dec[i][4];
        assign dec_invalid[i]      = ~dec[i][5];
    end

    assign all_ok = ~|dec_invalid;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock once the run is long enough, unlock on change.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLE: begin
                if (run_q == RUN_MAX) begin
                    state_d = changed ? SETTLE : LOCKED;
                end
            end
            LOCKED: begin
                if (changed) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // FSM outputs: decide whether this edge publishes or flags an error.
    always_comb begin
        evaluate = (state_q == SETTLE) && (run_q == RUN_MAX);
        pub_new  = 1'b0;
        err_new  = 1'b0;
        if (evaluate) begin
            if (all_ok) begin
                pub_new = !pub_q ||
                          ({dec_value, dec_blank} != {value, blank_mask});
            end else begin
                err_new = 1'b1;
            end
        end
    end

    // Published result registers and the update counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value        <= '0;
            blank_mask   <= '0;
            invalid_mask <= '0;
            value_valid  <= 1'b0;
            seg_error    <= 1'b0;
            update_count <= '0;
            pub_q        <= 1'b0;
        end else begin
            value_valid <= pub_new;
            seg_error   <= err_new;
            if (evaluate && all_ok) begin
                value        <= dec_value;
                blank_mask   <= dec_blank;
                invalid_mask <= '0;
                pub_q        <= 1'b1;
            end
            if (err_new) begin
                invalid_mask <= dec_invalid;
            end
            if (pub_new) begin
                update_count <= update_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed bench for seg7_readback_decoder: default instance plus a
// lit-high, short-run, 2-bit-counter instance for wrap checking.
module tb_seg7_readback_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  a1, a2, a3, a4;
    logic [6:0]  b1, b2, b3, b4;

    logic [15:0] a_value;
    logic [3:0]  a_blank;
    logic        a_valid;
    logic        a_err;
    logic [3:0]  a_inv;
    logic [7:0]  a_cnt;

    logic [15:0] b_value;
    logic [3:0]  b_blank;
    logic        b_valid;
    logic        b_err;
    logic [3:0]  b_inv;
    logic [1:0]  b_cnt;

    int errors = 0;
    int checks = 0;
    logic seen_v, seen_e, both;

    always #5 clk = ~clk;

    seg7_readback_decoder dut_a (
        .clk(clk), .reset(reset),
        .d1_seg(a1), .d2_seg(a2), .d3_seg(a3), .d4_seg(a4),
        .value(a_value), .blank_mask(a_blank),
        .value_valid(a_valid), .seg_error(a_err),
        .invalid_mask(a_inv), .update_count(a_cnt)
    );

    seg7_readback_decoder #(
        .STABLE_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(reset),
        .d1_seg(b1), .d2_seg(b2), .d3_seg(b3), .d4_seg(b4),
        .value(b_value), .blank_mask(b_blank),
        .value_valid(b_valid), .seg_error(b_err),
        .invalid_mask(b_inv), .update_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        seen_v |= a_valid;
        seen_e |= a_err;
        both   |= (a_valid & a_err) | (b_valid & b_err);
    endtask

    task automatic clr();
        seen_v = 1'b0;
        seen_e = 1'b0;
    endtask

    initial begin
        both = 1'b0;
        clr();
        a1 = 7'h7F; a2 = 7'h7F; a3 = 7'h7F; a4 = 7'h7F;
        b1 = 7'h00; b2 = 7'h00; b3 = 7'h00; b4 = 7'h00;

        // 1: reset, then all-off publishes blank at clock 5
        repeat (3) tick();
        chk("rst_value", a_value, 16'h0000);
        chk("rst_blank", a_blank, 4'h0);
        chk("rst_cnt", a_cnt, 8'd0);
        chk("rst_valid", a_valid, 1'b0);
        reset = 1'b1;
        clr();
        repeat (4) tick();
        chk("t1_early", seen_v, 1'b0);
        tick();
        chk("t1_valid", a_valid, 1'b1);
        chk("t1_value", a_value, 16'h0000);
        chk("t1_blank", a_blank, 4'hF);
        chk("t1_cnt", a_cnt, 8'd1);
        chk("t6_cnt0", b_cnt, 2'd1);
        tick();
        chk("t1_pulse1", a_valid, 1'b0);

        // 2: "1234" inverted on pins, strobe 5 clocks later
        a1 = ~7'h06; a2 = ~7'h5B; a3 = ~7'h4F; a4 = ~7'h66;
        clr();
        repeat (4) tick();
        chk("t2_early", seen_v, 1'b0);
        tick();
        chk("t2_valid", a_valid, 1'b1);
        chk("t2_value", a_value, 16'h1234);
        chk("t2_blank", a_blank, 4'h0);
        chk("t2_cnt", a_cnt, 8'd2);
        clr();
        repeat (6) tick();
        chk("t2_norepeat", seen_v, 1'b0);

        // 3: two-cycle glitch on d4 then back to "4"
        a4 = ~7'h6D;
        clr();
        repeat (2) tick();
        a4 = ~7'h66;
        repeat (8) tick();
        chk("t3_nopulse", seen_v, 1'b0);
        chk("t3_noerr", seen_e, 1'b0);
        chk("t3_value", a_value, 16'h1234);
        chk("t3_cnt", a_cnt, 8'd2);

        // 4: invalid code on d2
        a2 = ~7'h49;
        clr();
        repeat (4) tick();
        chk("t4_early", seen_e, 1'b0);
        tick();
        chk("t4_err", a_err, 1'b1);
        chk("t4_inv", a_inv, 4'b0100);
        chk("t4_value", a_value, 16'h1234);
        chk("t4_valid", a_valid, 1'b0);
        tick();
        chk("t4_pulse1", a_err, 1'b0);
        a2 = ~7'h5B;
        clr();
        repeat (6) tick();
        chk("t4_inv_clr", a_inv, 4'b0000);
        chk("t4_samepub", seen_v, 1'b0);
        chk("t4_cnt", a_cnt, 8'd2);

        // 6: counter wrap on the 2-bit instance
        b4 = 7'h06;
        repeat (3) tick();
        chk("t6_value1", b_value, 16'h0001);
        chk("t6_blank1", b_blank, 4'b1110);
        chk("t6_valid1", b_valid, 1'b1);
        chk("t6_cnt1", b_cnt, 2'd2);
        tick();
        b4 = 7'h5B;
        repeat (4) tick();
        chk("t6_cnt2", b_cnt, 2'd3);
        b4 = 7'h4F;
        repeat (4) tick();
        chk("t6_cnt3", b_cnt, 2'd0);
        b4 = 7'h66;
        repeat (4) tick();
        chk("t6_cnt4", b_cnt, 2'd1);
        chk("t6_value4", b_value, 16'h0004);

        // 5: reset mid-settle discards pending "ABCD"
        a1 = ~7'h77; a2 = ~7'h7C; a3 = ~7'h39; a4 = ~7'h5E;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("t5_rst_value", a_value, 16'h0000);
        chk("t5_rst_cnt", a_cnt, 8'd0);
        chk("t5_rst_blank", a_blank, 4'h0);
        tick();
        reset = 1'b1;
        clr();
        repeat (4) tick();
        chk("t5_early", seen_v, 1'b0);
        tick();
        chk("t5_valid", a_valid, 1'b1);
        chk("t5_value", a_value, 16'hABCD);
        chk("t5_cnt", a_cnt, 8'd1);

        chk("excl", both, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
